// File: rtl/sa_pkg.sv
// Shared definitions for the 3x3 systolic array feeder: element width,
// window origin table, FSM state encoding and flat-index helpers.
package sa_pkg;

    localparam int DW   = 8;
    localparam int NWIN = 4;

    // Window origins packed two bits per window, window 0 in the LSBs.
    localparam logic [7:0] WIN_R_TBL = 8'b01_01_00_00;
    localparam logic [7:0] WIN_C_TBL = 8'b01_00_01_00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_CAPTURE,
        ST_DONE
    } state_e;

    function automatic logic [1:0] win_row(input logic [1:0] w);
        return WIN_R_TBL[{w, 1'b0} +: 2];
    endfunction

    function automatic logic [1:0] win_col(input logic [1:0] w);
        return WIN_C_TBL[{w, 1'b0} +: 2];
    endfunction

    function automatic int a_idx(input int i, input int j);
        return 4 * i + j;
    endfunction

    function automatic int b_idx(input int i, input int j);
        return 3 * i + j;
    endfunction

endpackage

// File: rtl/sa3x3_feeder_lane.sv
// One skewed lane of the feeder: selects a[r+K][c+t-K] and b[K][t-K]
// while 0 <= t-K <= 2 and the stream is active, otherwise drives zero.
module feeder_lane #(
    parameter int K  = 0,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        r,
    input  logic [1:0]        c,
    input  logic [2:0]        t,
    input  logic [16*DW-1:0]  a_lat,
    input  logic [9*DW-1:0]   b_lat,
    output logic [DW-1:0]     din,
    output logic [DW-1:0]     win
);
    import sa_pkg::*;

    logic [2:0]    tk;
    logic          tap_on;
    int            a_sel;
    int            b_sel;
    logic [DW-1:0] din_d;
    logic [DW-1:0] win_d;
    logic [DW-1:0] din_q;
    logic [DW-1:0] win_q;

    always_comb begin
        tk     = t - 3'(K);
        tap_on = en && (t >= 3'(K)) && (tk <= 3'd2);
        a_sel  = a_idx(int'(r) + K, int'(c) + int'(tk));
        b_sel  = b_idx(K, int'(tk));
        din_d  = '0;
        win_d  = '0;
        if (tap_on) begin
            din_d = a_lat[a_sel*DW +: DW];
            win_d = b_lat[b_sel*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= '0;
            win_q <= '0;
        end else begin
            din_q <= din_d;
            win_q <= win_d;
        end
    end

    assign din = din_q;
    assign win = win_q;

endmodule

// File: rtl/sa3x3_feeder.sv
// Self-timed lane driver for the 3x3 systolic array: walks the four 2x2
// output windows of a latched 4x4 image. SA3X3_FEEDER_CYCLE_CNT_EN adds cycle stamps.
module sa3x3_feeder #(
    parameter int DW    = sa_pkg::DW,
    parameter int DRAIN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [16*DW-1:0] a_flat,
    input  logic [9*DW-1:0]  b_flat,
    output logic [DW-1:0]    din0,
    output logic [DW-1:0]    din1,
    output logic [DW-1:0]    din2,
    output logic [DW-1:0]    win0,
    output logic [DW-1:0]    win1,
    output logic [DW-1:0]    win2,
    output logic             clear,
    output logic             c00,
    output logic             c01,
    output logic             c10,
    output logic             c11,
    output logic             busy,
    output logic             done
`ifdef SA3X3_FEEDER_CYCLE_CNT_EN
    ,
    output logic [31:0]      cnt_start,
    output logic [31:0]      cnt_end
`endif
);
    import sa_pkg::*;

    state_e            state_q, state_d;
    logic [1:0]        w_q, w_d;
    logic [3:0]        cyc_q, cyc_d;
    logic [16*DW-1:0]  a_q, a_d;
    logic [9*DW-1:0]   b_q, b_d;
    logic              clear_q, clear_d;
    logic [NWIN-1:0]   capt_q, capt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              lane_en;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cyc_d   = cyc_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a_flat;
                    b_d     = b_flat;
                    w_d     = 2'd0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cyc_d   = 4'd0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (cyc_q == 4'd4) begin
                    cyc_d   = 4'd0;
                    state_d = ST_DRAIN;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            ST_DRAIN: begin
                if (cyc_q == 4'(DRAIN - 1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            ST_CAPTURE: begin
                if (w_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    w_d     = w_q + 2'd1;
                    state_d = ST_CLEAR;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        clear_d = (state_d == ST_CLEAR);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        capt_d  = '0;
        if (state_d == ST_CAPTURE) begin
            capt_d[w_d] = 1'b1;
        end
        lane_en = (state_d == ST_STREAM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            cyc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            clear_q <= 1'b0;
            capt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cyc_q   <= cyc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            clear_q <= clear_d;
            capt_q  <= capt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    logic [2:0][DW-1:0] din_lane;
    logic [2:0][DW-1:0] win_lane;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            feeder_lane #(
                .K  (gi),
                .DW (DW)
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .en    (lane_en),
                .r     (win_row(w_d)),
                .c     (win_col(w_d)),
                .t     (cyc_d[2:0]),
                .a_lat (a_q),
                .b_lat (b_q),
                .din   (din_lane[gi]),
                .win   (win_lane[gi])
            );
        end
    endgenerate

    assign din0  = din_lane[0];
    assign din1  = din_lane[1];
    assign din2  = din_lane[2];
    assign win0  = win_lane[0];
    assign win1  = win_lane[1];
    assign win2  = win_lane[2];
    assign clear = clear_q;
    assign c00   = capt_q[0];
    assign c01   = capt_q[1];
    assign c10   = capt_q[2];
    assign c11   = capt_q[3];
    assign busy  = busy_q;
    assign done  = done_q;

`ifdef SA3X3_FEEDER_CYCLE_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cnt_start_q, cnt_start_d;
    logic [31:0] cnt_end_q, cnt_end_d;

    always_comb begin
        cnt_d       = cnt_q + 32'd1;
        cnt_start_d = cnt_start_q;
        cnt_end_d   = cnt_end_q;
        if (state_q == ST_IDLE && start) begin
            cnt_start_d = cnt_q;
        end
        if (state_q == ST_DONE) begin
            cnt_end_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            cnt_start_q <= '0;
            cnt_end_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            cnt_start_q <= cnt_start_d;
            cnt_end_q   <= cnt_end_d;
        end
    end

    assign cnt_start = cnt_start_q;
    assign cnt_end   = cnt_end_q;
`endif

endmodule

// File: tb/tb_sa3x3_feeder.sv
// Directed bench for sa3x3_feeder: reset/idle, full schedule, lane values,
// ignored mid-run start, back-to-back start, mid-run reset and a second operand set.
`timescale 1ns/1ps
module tb_sa3x3_feeder;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [16*DW-1:0] a_flat;
    logic [9*DW-1:0]  b_flat;
    logic [DW-1:0]    din0, din1, din2, win0, win1, win2;
    logic             clear, c00, c01, c10, c11, busy, done;
`ifdef SA3X3_FEEDER_CYCLE_CNT_EN
    logic [31:0]      cnt_start, cnt_end;
`endif

    sa3x3_feeder #(.DW(DW), .DRAIN(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_flat (a_flat),
        .b_flat (b_flat),
        .din0   (din0),
        .din1   (din1),
        .din2   (din2),
        .win0   (win0),
        .win1   (win1),
        .win2   (win2),
        .clear  (clear),
        .c00    (c00),
        .c01    (c01),
        .c10    (c10),
        .c11    (c11),
        .busy   (busy),
        .done   (done)
`ifdef SA3X3_FEEDER_CYCLE_CNT_EN
        ,
        .cnt_start (cnt_start),
        .cnt_end   (cnt_end)
`endif
    );

    always #5 clk = ~clk;

    logic [6:0]  ctrl;
    logic [47:0] lanes;
    assign ctrl  = {busy, done, clear, c11, c10, c01, c00};
    assign lanes = {din0, din1, din2, win0, win1, win2};

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected {busy,done,clear,c11,c10,c01,c00} n cycles after start is sampled (DRAIN=3).
    function automatic logic [6:0] exp_ctrl(input int n);
        logic [6:0] e;
        e    = '0;
        e[6] = (n >= 1) && (n <= 41);
        e[5] = (n == 41);
        for (int w = 0; w < 4; w++) begin
            if (n == 1 + 10 * w)  e[4] = 1'b1;
            if (n == 10 + 10 * w) e[w] = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [63:0] lv(input int d0, input int d1, input int d2,
                                       input int w0, input int w1, input int w2);
        logic [47:0] v;
        v = {8'(d0), 8'(d1), 8'(d2), 8'(w0), 8'(w1), 8'(w2)};
        return 64'(v);
    endfunction

    task automatic load_index;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                a_flat[DW*(4*i+j) +: DW] = 8'(4*i + j);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                b_flat[DW*(3*i+j) +: DW] = 8'(3*i + j + 1);
    endtask

    task automatic load_alt;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                a_flat[DW*(4*i+j) +: DW] = 8'(16*(i+1) + j);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                b_flat[DW*(3*i+j) +: DW] = 8'(128 + 3*i + j);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a_flat = '0;
        b_flat = '0;
        tick;
        tick;
        rst = 1'b0;
        check_vec("reset_lanes", 64'(lanes), 64'd0);
        for (int i = 0; i < 20; i++) begin
            check_vec($sformatf("idle_ctrl_%0d", i), 64'(ctrl), 64'd0);
            tick;
        end
        $display("txn reset: 20 idle cycles observed");

        // Run 1: index pattern, operands scrambled after start, spurious start at T+15.
        load_index();
        start = 1'b1;
        tick;
        start  = 1'b0;
        a_flat = '1;
        b_flat = '1;
        for (int n = 1; n <= 42; n++) begin
            check_vec($sformatf("r1_ctrl_n%0d", n), 64'(ctrl), 64'(exp_ctrl(n)));
            case (n)
                1:  check_vec("r1_lanes_clear", 64'(lanes), 64'd0);
                2:  check_vec("r1_w0_t0", 64'(lanes), lv(0, 0, 0, 1, 0, 0));
                4:  check_vec("r1_w0_t2", 64'(lanes), lv(2, 5, 8, 3, 5, 7));
                6:  check_vec("r1_w0_t4", 64'(lanes), lv(0, 0, 10, 0, 0, 9));
                8:  check_vec("r1_lanes_drain", 64'(lanes), 64'd0);
                13: check_vec("r1_w1_t1", 64'(lanes), lv(2, 5, 0, 2, 4, 0));
                24: check_vec("r1_w2_t2", 64'(lanes), lv(6, 9, 12, 3, 5, 7));
                34: check_vec("r1_w3_t2", 64'(lanes), lv(7, 10, 13, 3, 5, 7));
                default: ;
            endcase
            start = (n == 15);
            if (n < 42) tick;
        end
        $display("txn run1: index pattern, 4 windows");

        // Run 2: start at T+42, then reset mid-window.
        load_index();
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            check_vec($sformatf("r2_ctrl_n%0d", n), 64'(ctrl), 64'(exp_ctrl(n)));
            if (n < 13) tick;
        end
        check_vec("r2_w1_t1", 64'(lanes), lv(2, 5, 0, 2, 4, 0));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_vec("rst_mid_ctrl", 64'(ctrl), 64'd0);
        check_vec("rst_mid_lanes", 64'(lanes), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check_vec($sformatf("rst_idle_%0d", i), 64'(ctrl), 64'd0);
        end
        $display("txn run2: back-to-back start, reset at T+13");

        // Run 3: fresh operands, full schedule from window 0.
        load_alt();
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int n = 1; n <= 42; n++) begin
            check_vec($sformatf("r3_ctrl_n%0d", n), 64'(ctrl), 64'(exp_ctrl(n)));
            if (n == 4)  check_vec("r3_w0_t2", 64'(lanes), lv(8'h12, 8'h21, 8'h30, 8'h82, 8'h84, 8'h86));
            if (n == 24) check_vec("r3_w2_t2", 64'(lanes), lv(8'h22, 8'h31, 8'h40, 8'h82, 8'h84, 8'h86));
            if (n < 42) tick;
        end
        $display("txn run3: alternate pattern, 4 windows");

`ifdef SA3X3_FEEDER_CYCLE_CNT_EN
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 41; i++) tick;
        check_vec("cnt_start", 64'(cnt_start), 64'd5);
        check_vec("cnt_end", 64'(cnt_end), 64'd46);
        $display("txn cnt: cycle stamps captured");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
